// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state encoding and owner codes for the data-memory arbiter.
package dmem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;
  localparam logic OWN_PIPE = 1'b0;
  localparam logic OWN_DBG  = 1'b1;
endpackage

// File: rtl/dmem_arbiter_age.sv
// arb_age_counter: saturating count of cycles debug has waited; sat_o lets debug pre-empt the pipeline.
module arb_age_counter #(
  parameter int LIM = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);
  localparam int W = LIM > 0 ? $clog2(LIM + 1) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  logic full;
  assign full  = cnt_q == W'(LIM);
  assign cnt_d = clr_i ? '0 : (inc_i & ~full) ? cnt_q + 1'b1 : cnt_q;
  assign sat_o = (LIM != 0) & full;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one synchronous data memory between the pipeline MEM stage and the debug unit.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p_req_i,
  input  logic              p_we_i,
  input  logic [ADDR_W-1:0] p_addr_i,
  input  logic [DATA_W-1:0] p_wdata_i,
  output logic [DATA_W-1:0] p_rdata_o,
  output logic              p_done_o,
  output logic              p_stall_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ack_o,
  output logic              m_en_o,
  output logic              m_we_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [DATA_W-1:0] m_wdata_o,
  input  logic [DATA_W-1:0] m_rdata_i,
  output logic              owner_o
);
  localparam logic [1:0] WAIT_LD = 2'(RD_LAT - 1);
  state_e            state_q, state_d;
  logic              owner_q, owner_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, p_rdata_q, p_rdata_d, d_rdata_q, d_rdata_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              sat, dbg_win, done;
  assign dbg_win = d_req_i & (~p_req_i | sat);
  arb_age_counter #(.LIM(STARVE_LIM)) u_age (
    .clk  (clk),
    .rst_n(rst_n),
    .inc_i(d_req_i & ~(state_q != IDLE & owner_q == OWN_DBG)),
    .clr_i(state_q == IDLE & dbg_win),
    .sat_o(sat)
  );
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    p_rdata_d = p_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      IDLE: if (p_req_i | d_req_i) begin
        state_d = ISSUE;
        owner_d = dbg_win ? OWN_DBG : OWN_PIPE;
        we_d    = dbg_win ? d_we_i : p_we_i;
        addr_d  = dbg_win ? d_addr_i : p_addr_i;
        wdata_d = dbg_win ? d_wdata_i : p_wdata_i;
      end
      ISSUE: begin
        state_d = we_q ? IDLE : WAIT;
        cnt_d   = WAIT_LD;
      end
      WAIT: if (cnt_q == 2'd0) begin
        state_d = RESP;
        if (owner_q == OWN_DBG) d_rdata_d = m_rdata_i;
        else p_rdata_d = m_rdata_i;
      end else cnt_d = cnt_q - 2'd1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= OWN_PIPE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      p_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      p_rdata_q <= p_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end
  // writes complete in ISSUE, reads in RESP
  assign done      = (state_q == ISSUE & we_q) | state_q == RESP;
  assign p_done_o  = done & owner_q == OWN_PIPE;
  assign d_ack_o   = done & owner_q == OWN_DBG;
  assign p_stall_o = p_req_i & ~p_done_o;
  assign m_en_o    = state_q == ISSUE;
  assign m_we_o    = m_en_o & we_q;
  assign m_addr_o  = addr_q;
  assign m_wdata_o = wdata_q;
  assign p_rdata_o = p_rdata_q;
  assign d_rdata_o = d_rdata_q;
  assign owner_o   = owner_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: two arbiters (RD_LAT=1 and RD_LAT=4) each on a latency-accurate memory model.
module tb_dmem_arbiter;
  logic clk, rst_n;
  logic p_req[2], p_we[2], d_req[2], d_we[2];
  logic [31:0] p_addr[2], p_wdata[2], d_addr[2], d_wdata[2];
  logic [31:0] p_rdata[2], d_rdata[2], m_addr[2], m_wdata[2], m_rdata[2];
  logic p_done[2], p_stall[2], d_ack[2], m_en[2], m_we[2], owner[2];
  int total = 0, bad = 0;

  typedef struct {
    string nm;
    bit dbg;
    bit we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    int lat;
  } vec_t;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = g == 0 ? 1 : 4;
    logic [31:0] mem [16];
    logic [31:0] pipe [LAT];
    logic [LAT-1:0] vld;
    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(LAT), .STARVE_LIM(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .p_req_i(p_req[g]), .p_we_i(p_we[g]), .p_addr_i(p_addr[g]), .p_wdata_i(p_wdata[g]),
      .p_rdata_o(p_rdata[g]), .p_done_o(p_done[g]), .p_stall_o(p_stall[g]),
      .d_req_i(d_req[g]), .d_we_i(d_we[g]), .d_addr_i(d_addr[g]), .d_wdata_i(d_wdata[g]),
      .d_rdata_o(d_rdata[g]), .d_ack_o(d_ack[g]),
      .m_en_o(m_en[g]), .m_we_o(m_we[g]), .m_addr_o(m_addr[g]), .m_wdata_o(m_wdata[g]),
      .m_rdata_i(m_rdata[g]), .owner_o(owner[g])
    );
    // read data is only driven during the single cycle it is valid
    always @(posedge clk) begin
      if (m_en[g] & m_we[g]) mem[m_addr[g][3:0]] <= m_wdata[g];
      for (int i = LAT - 1; i > 0; i--) begin
        vld[i]  <= vld[i-1];
        pipe[i] <= pipe[i-1];
      end
      vld[0]  <= m_en[g] & ~m_we[g];
      pipe[0] <= mem[m_addr[g][3:0]];
    end
    assign m_rdata[g] = vld[LAT-1] ? pipe[LAT-1] : 32'hBAD0_BAD0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(string nm, bit dbg, bit we, logic [31:0] a, logic [31:0] w,
                              logic [31:0] e, int lat);
    vec_t v;
    v.nm = nm; v.dbg = dbg; v.we = we; v.addr = a; v.wdata = w; v.exp = e; v.lat = lat;
    return v;
  endfunction

  task automatic txn(input int u, input vec_t v);
    int k = 0, ens = 0, other = 0, stl = 0;
    logic [31:0] ma = 0, md = 0;
    logic mw = 0, seen = 0;
    @(negedge clk);
    if (v.dbg) begin
      d_req[u] = 1; d_we[u] = v.we; d_addr[u] = v.addr; d_wdata[u] = v.wdata;
    end else begin
      p_req[u] = 1; p_we[u] = v.we; p_addr[u] = v.addr; p_wdata[u] = v.wdata;
    end
    #1;
    if (!v.dbg) chk({v.nm, "_stall0"}, 32'(p_stall[u]), 1);
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (m_en[u]) begin ens++; ma = m_addr[u]; md = m_wdata[u]; mw = m_we[u]; end
      if (v.dbg ? p_done[u] : d_ack[u]) other++;
      seen = v.dbg ? d_ack[u] : p_done[u];
      if (!v.dbg && (p_stall[u] == seen)) stl++;
    end
    p_req[u] = 0;
    d_req[u] = 0;
    chk({v.nm, "_lat"}, 32'(k), 32'(v.lat));
    chk({v.nm, "_men_cycles"}, 32'(ens), 1);
    chk({v.nm, "_maddr"}, ma, v.addr);
    chk({v.nm, "_mwe"}, 32'(mw), 32'(v.we));
    chk({v.nm, "_nonowner"}, 32'(other), 0);
    if (!v.dbg) chk({v.nm, "_stall"}, 32'(stl), 0);
    if (v.we) chk({v.nm, "_mwdata"}, md, v.wdata);
    else chk({v.nm, "_rdata"}, v.dbg ? d_rdata[u] : p_rdata[u], v.exp);
  endtask

  initial begin
    vec_t tbl[7];
    int pd, da, np, ns, acks;
    tbl[0] = mk("p_wr1",  0, 1, 1, 10,            0,            1);
    tbl[1] = mk("p_rd1",  0, 0, 1, 0,             10,           3);
    tbl[2] = mk("d_wr2",  1, 1, 2, 32'h55,        0,            1);
    tbl[3] = mk("d_rd2",  1, 0, 2, 0,             32'h55,       3);
    tbl[4] = mk("p_wr3",  0, 1, 3, 32'hA5A5_0001, 0,            1);
    tbl[5] = mk("d_rd3",  1, 0, 3, 0,             32'hA5A5_0001, 3);
    tbl[6] = mk("p_rd2",  0, 0, 2, 0,             32'h55,       3);
    for (int u = 0; u < 2; u++) begin
      p_req[u] = 0; p_we[u] = 0; p_addr[u] = 0; p_wdata[u] = 0;
      d_req[u] = 0; d_we[u] = 0; d_addr[u] = 0; d_wdata[u] = 0;
    end
    rst_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_ctl", {31'd0, m_en[0] | m_we[0] | owner[0] | p_done[0] | d_ack[0] | p_stall[0]}, 0);
    chk("rst_maddr", m_addr[0] | m_wdata[0], 0);
    chk("rst_rdata", p_rdata[0] | d_rdata[0], 0);
    rst_n = 1;

    for (int i = 0; i < 7; i++) txn(0, tbl[i]);
    chk("d_rdata_hold", d_rdata[0], 32'hA5A5_0001);

    // simultaneous reads at age 0: pipeline first, debug second
    @(negedge clk);
    p_req[0] = 1; p_we[0] = 0; p_addr[0] = 1;
    d_req[0] = 1; d_we[0] = 0; d_addr[0] = 2;
    pd = 0; da = 0;
    for (int k = 1; k <= 12 && da == 0; k++) begin
      @(negedge clk);
      if (p_done[0]) begin pd = k; p_req[0] = 0; chk("A_prdata", p_rdata[0], 10); end
      if (d_ack[0]) begin da = k; d_req[0] = 0; chk("A_drdata", d_rdata[0], 32'h55); end
    end
    p_req[0] = 0; d_req[0] = 0;
    chk("A_pdone_cycle", 32'(pd), 3);
    chk("A_dack_cycle", 32'(da), 7);

    // pipeline writes every chance it gets; debug must win once age saturates
    @(negedge clk);
    p_req[0] = 1; p_we[0] = 1; p_addr[0] = 5; p_wdata[0] = 77;
    d_req[0] = 1; d_we[0] = 0; d_addr[0] = 1;
    np = 0; da = 0; ns = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (p_done[0]) np++;
      if (k >= 5 && k <= 7 && p_stall[0] && owner[0]) ns++;
      if (d_ack[0] && da == 0) begin da = k; d_req[0] = 0; chk("B_drdata", d_rdata[0], 10); end
    end
    p_req[0] = 0; d_req[0] = 0;
    chk("B_dack_cycle", 32'(da), 7);
    chk("B_pdones", 32'(np), 2);
    chk("B_stall_dbg", 32'(ns), 3);

    // async reset in WAIT of a debug read
    @(negedge clk);
    d_req[0] = 1; d_we[0] = 0; d_addr[0] = 2;
    repeat (2) @(negedge clk);
    rst_n = 0; d_req[0] = 0;
    #1;
    chk("C_rst_ctl", {31'd0, m_en[0] | m_we[0] | owner[0] | p_done[0] | d_ack[0] | p_stall[0]}, 0);
    chk("C_rst_maddr", m_addr[0] | m_wdata[0], 0);
    chk("C_rst_rdata", p_rdata[0] | d_rdata[0], 0);
    @(negedge clk);
    rst_n = 1;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (d_ack[0]) acks++;
    end
    chk("C_no_ack", 32'(acks), 0);
    txn(0, mk("C_reissue", 1, 0, 2, 0, 32'h55, 3));

    // RD_LAT=4 instance
    txn(1, mk("L4_p_wr7", 0, 1, 7, 32'hDEAD_BEEF, 0, 1));
    txn(1, mk("L4_p_rd7", 0, 0, 7, 0, 32'hDEAD_BEEF, 6));
    txn(1, mk("L4_d_rd7", 1, 0, 7, 0, 32'hDEAD_BEEF, 6));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
